// File: rtl/wino_pkg.sv
// Shared definitions for the layer controller: FSM state encoding and
// default parameter values used by the top and its sub-module.
package wino_pkg;

  // Layer sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREPARE  = 2'd1,
    COMPLETE = 2'd2,
    DONE     = 2'd3
  } layer_state_t;

  // Default parameter constants
  localparam int DEF_ID_W   = 4;
  localparam int DEF_OD_W   = 8;
  localparam int DEF_DIM_W  = 9;
  localparam int DEF_BLK_W  = 8;
  localparam int DEF_OD_PAR = 2;
  localparam int DEF_TILE   = 6;

endpackage

// File: rtl/layer_controller_blk_count.sv
// blk_count: number of TILE-pixel blocks covering a feature-map edge.
// ceil(dim/TILE), a zero-sized edge still yields one block, and the
// result saturates at the all-ones value of the output width.
module blk_count
  import wino_pkg::*;
#(
  parameter int DIM_W = DEF_DIM_W,
  parameter int BLK_W = DEF_BLK_W,
  parameter int TILE  = DEF_TILE
) (
  input  logic [DIM_W-1:0] dim_i,
  output logic [BLK_W-1:0] blk_o
);

  // One extra bit so dim + TILE-1 cannot wrap before the divide
  localparam int SW = DIM_W + 1;
  localparam longint unsigned BLK_MAX = (64'd1 << BLK_W) - 64'd1;

  logic [SW-1:0] quot;

  // Ceil-divide, then apply the zero and saturation corner cases
  always_comb begin
    quot = ({1'b0, dim_i} + SW'(TILE - 1)) / SW'(TILE);
    if (dim_i == '0)
      blk_o = BLK_W'(1);
    else if (64'(quot) > BLK_MAX)
      blk_o = '1;
    else
      blk_o = BLK_W'(quot);
  end

endmodule

// File: rtl/layer_controller.sv
// layer_controller: sequences one convolution layer as a series of passes.
// Each pass covers OD_PAR output channels for one input channel; od groups
// are the inner loop, input channels the outer loop. The data controller
// runs a pass while data_prepare_o is high and reports back via
// loop_finished_i.
module layer_controller
  import wino_pkg::*;
#(
  parameter int ID_W   = DEF_ID_W,
  parameter int OD_W   = DEF_OD_W,
  parameter int DIM_W  = DEF_DIM_W,
  parameter int BLK_W  = DEF_BLK_W,
  parameter int OD_PAR = DEF_OD_PAR,
  parameter int TILE   = DEF_TILE
) (
  input  logic              clk,
  input  logic              reset,
  // layer config handshake
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [ID_W-1:0]   cfg_id_i,
  input  logic [OD_W-1:0]   cfg_od_i,
  input  logic [DIM_W-1:0]  cfg_width_i,
  input  logic [DIM_W-1:0]  cfg_height_i,
  input  logic              cfg_size_type_i,
  // control from the data path
  input  logic              abort_i,
  input  logic              loop_finished_i,
  // pass control
  output logic              data_prepare_o,
  output logic [OD_W-1:0]   weight_od_o,
  output logic [ID_W-1:0]   weight_id_o,
  output logic [ID_W-1:0]   data_id_o,
  output logic [OD_PAR-1:0] od_mask_o,
  output logic              first_id_o,
  output logic [BLK_W-1:0]  block_width_o,
  output logic [BLK_W-1:0]  block_height_o,
  output logic              size_type_o,
  // status
  output logic              busy_o,
  output logic              conv_completed_o
);

  localparam logic [OD_W:0] OD_STEP = (OD_W + 1)'(OD_PAR);

  layer_state_t     state_q;
  logic [OD_W-1:0]  od_total_q;
  logic [ID_W-1:0]  id_total_q;
  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] height_q;
  logic             size_type_q;
  logic [OD_W-1:0]  od_base_q;
  logic [ID_W-1:0]  id_q;
  logic             data_prepare_q;
  logic             conv_completed_q;

  // Counter arithmetic one bit wider than the counters so sums never wrap
  logic [OD_W:0]    od_step_d;
  logic [ID_W:0]    id_inc_d;
  logic             last_grp_d;
  logic             last_id_d;

  // Next od group / input channel and the end-of-loop conditions
  always_comb begin
    od_step_d  = {1'b0, od_base_q} + OD_STEP;
    id_inc_d   = {1'b0, id_q} + (ID_W + 1)'(1);
    last_grp_d = (od_step_d >= {1'b0, od_total_q});
    last_id_d  = (id_inc_d == {1'b0, id_total_q});
  end

  // Layer FSM with its counters, config registers and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      od_total_q       <= '0;
      id_total_q       <= '0;
      width_q          <= '0;
      height_q         <= '0;
      size_type_q      <= 1'b0;
      od_base_q        <= '0;
      id_q             <= '0;
      data_prepare_q   <= 1'b0;
      conv_completed_q <= 1'b0;
    end else begin
      conv_completed_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_valid_i) begin
            od_total_q  <= cfg_od_i;
            id_total_q  <= cfg_id_i;
            width_q     <= cfg_width_i;
            height_q    <= cfg_height_i;
            size_type_q <= cfg_size_type_i;
            od_base_q   <= '0;
            id_q        <= '0;
            // An empty layer has no passes: report completion straight away
            if (cfg_od_i == '0 || cfg_id_i == '0) begin
              state_q          <= DONE;
              conv_completed_q <= 1'b1;
            end else begin
              state_q        <= PREPARE;
              data_prepare_q <= 1'b1;
            end
          end
        end
        PREPARE: begin
          if (abort_i) begin
            state_q        <= IDLE;
            od_base_q      <= '0;
            id_q           <= '0;
            data_prepare_q <= 1'b0;
          end else if (loop_finished_i) begin
            state_q        <= COMPLETE;
            data_prepare_q <= 1'b0;
          end
        end
        COMPLETE: begin
          if (abort_i) begin
            state_q   <= IDLE;
            od_base_q <= '0;
            id_q      <= '0;
          end else begin
            if (last_grp_d) begin
              od_base_q <= '0;
              id_q      <= id_inc_d[ID_W-1:0];
            end else begin
              od_base_q <= od_step_d[OD_W-1:0];
            end
            if (last_grp_d && last_id_d) begin
              state_q          <= DONE;
              conv_completed_q <= 1'b1;
            end else begin
              state_q        <= PREPARE;
              data_prepare_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q        <= IDLE;
          data_prepare_q <= 1'b0;
        end
      endcase
    end
  end

  // Lane k is live while its output channel lies inside the layer
  for (genvar k = 0; k < OD_PAR; k++) begin : g_mask
    assign od_mask_o[k] = (({1'b0, od_base_q} + (OD_W + 1)'(k)) < {1'b0, od_total_q});
  end

  blk_count #(
    .DIM_W (DIM_W),
    .BLK_W (BLK_W),
    .TILE  (TILE)
  ) u_blk_w (
    .dim_i (width_q),
    .blk_o (block_width_o)
  );

  blk_count #(
    .DIM_W (DIM_W),
    .BLK_W (BLK_W),
    .TILE  (TILE)
  ) u_blk_h (
    .dim_i (height_q),
    .blk_o (block_height_o)
  );

  assign cfg_ready_o      = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign data_prepare_o   = data_prepare_q;
  assign conv_completed_o = conv_completed_q;
  assign weight_od_o      = od_base_q;
  assign weight_id_o      = id_q;
  assign data_id_o        = id_q;
  assign first_id_o       = (id_q == '0);
  assign size_type_o      = size_type_q;

endmodule

// File: doc/layer_controller.md
LAYER_CONTROLLER -- requirements
Module: layer_controller

Interface
- REQ-001 Parameter ID_W, default 4: width of the input-depth (channel) count and counter.
- REQ-002 Parameter OD_W, default 8: width of the output-depth count and counter.
- REQ-003 Parameter DIM_W, default 9: width of the feature-map width/height.
- REQ-004 Parameter BLK_W, default 8: width of the block-count outputs.
- REQ-005 Parameter OD_PAR, default 2: output channels processed per pass, >=1.
- REQ-006 Parameter TILE, default 6: output pixels per block edge.
- REQ-007 clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
- REQ-008 cfg_valid_i  in  1; cfg_ready_o  out  1: layer-config handshake, transfers when both are high.
- REQ-009 cfg_id_i  in  ID_W; cfg_od_i  in  OD_W; cfg_width_i, cfg_height_i  in  DIM_W; cfg_size_type_i  in  1: layer config.
- REQ-010 abort_i  in  1: cancels the current layer.
- REQ-011 loop_finished_i  in  1: the data controller has finished one pass.
- REQ-012 data_prepare_o  out  1: level, the data controller is to run the current pass.
- REQ-013 weight_od_o  out  OD_W; weight_id_o, data_id_o  out  ID_W: current od base and id.
- REQ-014 od_mask_o  out  OD_PAR: valid output lanes; first_id_o  out  1: the pass is id 0 (accumulator clear).
- REQ-015 block_width_o, block_height_o  out  BLK_W; size_type_o  out  1.
- REQ-016 busy_o  out  1; conv_completed_o  out  1: one-cycle done pulse.

Function
- REQ-017 FSM states: IDLE, PREPARE, COMPLETE, DONE; cfg_ready_o = (state==IDLE).
- REQ-018 IDLE, on a config handshake: register all cfg fields, clear od_base and id to 0, go to PREPARE; if cfg_od_i==0 or cfg_id_i==0, go to DONE instead.
- REQ-019 PREPARE: data_prepare_o=1; on loop_finished_i go to COMPLETE; loop_finished_i is ignored in every other state.
- REQ-020 COMPLETE lasts exactly one cycle with data_prepare_o=0 and advances the counters.
  - Not the last od group (od_base+OD_PAR < od_total): od_base += OD_PAR.
  - Otherwise: od_base=0 and id+=1.
  - Next state is DONE if this was the last od group and id==id_total-1, else PREPARE.
- REQ-021 Counter arithmetic is carried out at OD_W+1 / ID_W+1 bits so sums do not wrap.
- REQ-022 DONE: conv_completed_o=1 for exactly one cycle, then IDLE; the registered config holds until the next handshake.
- REQ-023 od_mask_o bit k = (od_base+k < od_total); the tail pass masks the unused lanes.
- REQ-024 block_width_o = ceil(width/TILE), with 0 mapped to 1 and saturating at 2^BLK_W-1; block_height_o is computed the same way from height. Both are combinational from the registered config.
- REQ-025 abort_i in PREPARE or COMPLETE: go to IDLE the next cycle and zero the counters, with no conv_completed_o; abort_i has priority over loop_finished_i; abort_i is ignored in IDLE and DONE.
- REQ-026 busy_o = (state != IDLE); first_id_o = (id==0); size_type_o is the registered value.

Reset
- REQ-027 On reset the FSM goes to IDLE and every counter and config register is cleared; reset has priority over all other inputs.
- REQ-028 Output values under reset: cfg_ready_o=1; busy_o=0; data_prepare_o=0; conv_completed_o=0; od_mask_o=0 (od_total=0); first_id_o=1; block_width_o=1 and block_height_o=1; all other outputs 0.

Structure
- REQ-029 A shared package wino_pkg holds the state enum layer_state_t and the default parameter constants.
- REQ-030 One sub-module, blk_count (ceil-divide by TILE with saturation), is instantiated once for width and once for height.

Verification
- REQ-031 Scenario: config id=2, od=4, OD_PAR=2, loop_finished_i pulsed on each PREPARE -> (od_base,id) sequence (0,0),(2,0),(0,1),(2,1); conv_completed_o pulses once; 4 PREPARE phases.
- REQ-032 Scenario: od=5, id=1 -> passes at od_base 0, 2, 4; od_mask_o = 11, 11, 01.
- REQ-033 Scenario: width 0, 6, 7, 60, 511 with TILE=6 -> block_width_o = 1, 1, 2, 10, 86.
- REQ-034 Scenario: cfg_od_i=0 -> DONE on the cycle after the handshake, conv_completed_o pulses, no PREPARE.
- REQ-035 Scenario: abort_i and loop_finished_i asserted together in PREPARE -> IDLE, no completion pulse, cfg_ready_o=1.
- REQ-036 Scenario: reset asserted mid-layer during COMPLETE -> all outputs at their REQ-028 values the next cycle, and a new config is accepted.
